arb_req_stage: RTL
==================

# arb_req_stage

Upstream request staging block for the round-robin arbiter. It accepts up to REQ_NUM independent valid/ready request streams and parks one word per port in a holding register. It presents the occupied ports as the arbiter's `req` vector, consumes the returned one-hot grant, and moves the granted word into a single registered valid/ready output. It decouples requesters from the arbiter's combinational req→gnt path and guarantees `req` is only raised when the output slot can accept.

## Interface
Parameters:
- REQ_NUM, 2, number of requesting ports (≥2)
- DATA_W, 32, payload width per port

Ports:
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  REQ_NUM  per-port request valid
- in_ready  output  REQ_NUM  per-port accept
- in_data  input  REQ_NUM*DATA_W  port i payload at [i*DATA_W +: DATA_W]
- arb_req  output  REQ_NUM  request vector to arbiter `req`
- arb_gnt  input  REQ_NUM  grant from arbiter `gnt`, same cycle
- out_valid  output  1  staged word valid
- out_ready  input  1  downstream accept
- out_data  output  DATA_W  granted payload
- out_src  output  REQ_NUM  one-hot source port of out_data
- gnt_err  output  1  sticky illegal-grant flag (see Configuration)

## Operation
- Per port i: holding register hold_vld[i]/hold_data[i].
- slot_free = ~out_valid | out_ready.
- arb_req[i] = hold_vld[i] & slot_free. All zero when the slot is blocked, so the arbiter sees no request and does not grant.
- Effective grant g = arb_gnt & arb_req. If g has more than one bit set, only the lowest-index bit is used. pop = that single bit.
- in_ready[i] = ~hold_vld[i] | pop[i]. A full port may refill in the same cycle it is popped.
- Hold update: in_valid[i]&in_ready[i] loads in_data slice and sets hold_vld[i]. Otherwise pop[i] clears hold_vld[i]. Load and pop together leave hold_vld[i]=1 with new data.
- Output update:
  - |pop loads out_data=hold_data[k], out_src=pop, out_valid=1.
  - Else out_valid&out_ready clears out_valid. out_data and out_src hold their last value.
- Words from one port are delivered in acceptance order. The block never reorders or drops words.
- Fairness is entirely the arbiter's. This block adds no priority.

## Timing
- Reset (asynchronous, immediate): hold_vld=0, out_valid=0, out_data=0, out_src=0, gnt_err=0. Hence arb_req=0 and in_ready=all ones while rst_n low and after release.
- Latency: word accepted at edge N is in hold. Earliest out_valid is after edge N+1, i.e. 2 cycles from in handshake to out_valid.
- Throughput: 1 word/cycle aggregate while out_ready=1. 1 word/cycle per port when that port is granted every cycle.
- Backpressure: out_valid=1 & out_ready=0 forces arb_req=0. All holds freeze and in_ready[i]=~hold_vld[i].
- out_ready rising with a pending hold: pop and output reload happen at the same edge, with no bubble.
- arb_gnt is not required to be zero when arb_req=0. It is masked.
- Reset mid-operation discards all held and staged words with no handshake.

## Configuration
- Macro ARB_REQ_STAGE_GNT_CHK_EN.
- Defined: gnt_err sets and stays set until reset when arb_gnt has any bit outside arb_req, or more than one bit of g is set. Data-path behaviour (lowest-index bit wins) is unchanged.
- Undefined: gnt_err tied 0. No check logic.

## Test plan
- Reset then idle: all outputs 0, in_ready=2'b11, arb_req=2'b00 for 10 cycles.
- REQ_NUM=2, port0 sends 0xA0, out_ready=1, arb_gnt=arb_req: out_valid after 2 cycles with out_data=0xA0, out_src=2'b01, then low.
- Both ports hold words, out_ready=0 for 5 cycles: arb_req=00 throughout, in_ready=00. Release out_ready with arbiter granting 10: out_src=10 next cycle, then 01 the cycle after.
- Port1 streams 0x10..0x17 back-to-back, always granted, out_ready=1: in_ready[1] stays 1, out_data 0x10..0x17 on consecutive cycles.
- With macro: force arb_gnt=2'b11 while arb_req=2'b11. Port0 pops, gnt_err=1 next cycle and stays 1 until rst_n low.
- Assert rst_n low while both holds and output are full: all outputs 0 immediately. After release no stale word ever appears on out_data with out_valid=1.

Source files
------------

// File: rtl/arb_req_stage_if.sv
// arb_req_stage_if: request-side, arbiter and output signals of the arbiter request staging block.
interface arb_req_stage_if #(parameter int REQ_NUM = 2, parameter int DATA_W = 32);
  logic [REQ_NUM-1:0]        in_valid;
  logic [REQ_NUM-1:0]        in_ready;
  logic [REQ_NUM*DATA_W-1:0] in_data;
  logic [REQ_NUM-1:0]        arb_req;
  logic [REQ_NUM-1:0]        arb_gnt;
  logic                      out_valid;
  logic                      out_ready;
  logic [DATA_W-1:0]         out_data;
  logic [REQ_NUM-1:0]        out_src;
  logic                      gnt_err;
  modport master (output in_valid, in_data, arb_gnt, out_ready,
                  input  in_ready, arb_req, out_valid, out_data, out_src, gnt_err);
  modport slave  (input  in_valid, in_data, arb_gnt, out_ready,
                  output in_ready, arb_req, out_valid, out_data, out_src, gnt_err);
endinterface

// File: rtl/arb_req_stage.sv
// arb_req_stage: parks one word per port, requests the arbiter only when the output slot can accept, stages the granted word.
// ARB_REQ_STAGE_GNT_CHK_EN enables the sticky illegal-grant flag gnt_err.
module arb_req_stage #(
  parameter int REQ_NUM = 2,
  parameter int DATA_W  = 32
) (
  input logic             clk,
  input logic             rst_n,
  arb_req_stage_if.slave  bus
);
  logic [REQ_NUM-1:0] hold_vld, g, pop, src;
  logic [DATA_W-1:0]  hold_data [REQ_NUM];
  logic [DATA_W-1:0]  pop_data, data;
  logic               vld, slot_free;
  // multiple grant bits collapse to the lowest index
  always_comb begin
    slot_free = ~vld | bus.out_ready;
    bus.arb_req = hold_vld & {REQ_NUM{slot_free}};
    g = bus.arb_gnt & bus.arb_req;
    pop = g & (~g + REQ_NUM'(1));
    bus.in_ready = ~hold_vld | pop;
    pop_data = '0;
    for (int i = 0; i < REQ_NUM; i++) pop_data |= pop[i] ? hold_data[i] : '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_vld <= '0;
      for (int i = 0; i < REQ_NUM; i++) hold_data[i] <= '0;
    end else begin
      for (int i = 0; i < REQ_NUM; i++) begin
        if (bus.in_valid[i] & bus.in_ready[i]) begin
          hold_vld[i]  <= 1'b1;
          hold_data[i] <= bus.in_data[i*DATA_W +: DATA_W];
        end else if (pop[i]) hold_vld[i] <= 1'b0;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld  <= 1'b0;
      data <= '0;
      src  <= '0;
    end else if (|pop) begin
      vld  <= 1'b1;
      data <= pop_data;
      src  <= pop;
    end else if (vld & bus.out_ready) vld <= 1'b0;
  end
  assign bus.out_valid = vld;
  assign bus.out_data  = data;
  assign bus.out_src   = src;
`ifdef ARB_REQ_STAGE_GNT_CHK_EN
  logic err;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err <= 1'b0;
    else if ((|(bus.arb_gnt & ~bus.arb_req)) | (g != pop)) err <= 1'b1;
  end
  assign bus.gnt_err = err;
`else
  assign bus.gnt_err = 1'b0;
`endif
endmodule
